vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 114 +++++++++++
 tb/tb_vga_timing_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blank and
// start-of-line/frame strobes, advanced by a pixel clock enable.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  output logic [CW-1:0]      pos_x,
  output logic [CW-1:0]      pos_y,
  output logic               display_on,
  output logic               hsync,
  output logic               vsync,
  output logic               vblank,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_size_check
    $error("vga_timing_gen: H_TOTAL or V_TOTAL does not fit in CW bits");
  end

  // Sync windows are stored as inclusive [start, last] so no bound ever needs CW+1 bits.
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic          HS_ACT   = HSYNC_POL;
  localparam logic          VS_ACT   = VSYNC_POL;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  logic [CW-1:0] next_x;
  logic [CW-1:0] next_y;
  logic          line_wrap;
  logic          frame_wrap;

  // Next raster position; decodes below use it so outputs line up with pos_x/pos_y.
  always_comb begin
    next_x     = pos_x;
    next_y     = pos_y;
    line_wrap  = 1'b0;
    frame_wrap = 1'b0;
    if (state == IDLE) begin
      next_x = '0;
      next_y = '0;
    end else if (pos_x == H_LAST) begin
      next_x    = '0;
      line_wrap = 1'b1;
      if (pos_y == V_LAST) begin
        next_y     = '0;
        frame_wrap = 1'b1;
      end else begin
        next_y = pos_y + CW'(1);
      end
    end else begin
      next_x = pos_x + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pos_x       <= '0;
      pos_y       <= '0;
      frame_count <= '0;
      display_on  <= 1'b0;
      vblank      <= 1'b0;
      hsync       <= ~HS_ACT;
      vsync       <= ~VS_ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        state       <= RUN;
        pos_x       <= next_x;
        pos_y       <= next_y;
        display_on  <= (next_x < H_VIS) && (next_y < V_VIS);
        vblank      <= (next_y >= V_VIS);
        hsync       <= (next_x >= HS_START && next_x <= HS_LAST) ? HS_ACT : ~HS_ACT;
        vsync       <= (next_y >= VS_START && next_y <= VS_LAST) ? VS_ACT : ~VS_ACT;
        // The IDLE->RUN edge starts the first frame without counting a completed one.
        line_start  <= (state == IDLE) || line_wrap;
        frame_start <= (state == IDLE) || frame_wrap;
        if (frame_wrap) begin
          frame_count <= frame_count + FRAME_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed vector table on the default 640x480 timing,
// plus a tiny-raster instance tracked cycle by cycle through frames and resets.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ce;
  logic        ce_s;

  logic [9:0]  pos_x, pos_y;
  logic        display_on, hsync, vsync, vblank, line_start, frame_start;
  logic [15:0] frame_count;

  logic [3:0]  s_pos_x, s_pos_y;
  logic        s_display_on, s_hsync, s_vsync, s_vblank, s_line_start, s_frame_start;
  logic [1:0]  s_frame_count;

  vga_timing_gen dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .pos_x(pos_x), .pos_y(pos_y), .display_on(display_on), .hsync(hsync),
    .vsync(vsync), .vblank(vblank), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4), .FRAME_W(2)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .ce(ce_s),
    .pos_x(s_pos_x), .pos_y(s_pos_y), .display_on(s_display_on), .hsync(s_hsync),
    .vsync(s_vsync), .vblank(s_vblank), .line_start(s_line_start),
    .frame_start(s_frame_start), .frame_count(s_frame_count)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic ce;
    int   x;
    int   y;
    logic disp;
    logic hs;
    logic ls;
    logic fs;
  } vec_t;

  vec_t vecs[7];

  // Expected state of the 14x7 raster (H 8/2/2/2, V 4/1/1/1, active-high syncs).
  bit   m_idle;
  int   mx, my, mfc;
  logic m_disp, m_hs, m_vs, m_vb, m_ls, m_fs;

  function automatic logic [63:0] pack_def(int x, int y, logic disp, logic hs, logic vs,
                                           logic vb, logic ls, logic fs, int fc);
    return {22'd0, 10'(x), 10'(y), disp, hs, vs, vb, ls, fs, 16'(fc)};
  endfunction

  function automatic logic [63:0] def_act();
    return {22'd0, pos_x, pos_y, display_on, hsync, vsync, vblank, line_start, frame_start,
            frame_count};
  endfunction

  function automatic logic [63:0] small_act();
    return {48'd0, s_pos_x, s_pos_y, s_display_on, s_hsync, s_vsync, s_vblank, s_line_start,
            s_frame_start, s_frame_count};
  endfunction

  function automatic logic [63:0] small_exp();
    return {48'd0, 4'(mx), 4'(my), m_disp, m_hs, m_vs, m_vb, m_ls, m_fs, 2'(mfc)};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic c, input int n);
    ce = c;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    mx = 0; my = 0; mfc = 0;
    m_disp = 1'b0; m_hs = 1'b0; m_vs = 1'b0; m_vb = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
  endtask

  task automatic model_step(input logic c);
    m_ls = 1'b0;
    m_fs = 1'b0;
    if (c) begin
      if (m_idle) begin
        m_idle = 1'b0;
        mx = 0; my = 0;
        m_ls = 1'b1; m_fs = 1'b1;
      end else if (mx == 13) begin
        mx = 0;
        m_ls = 1'b1;
        if (my == 6) begin
          my = 0;
          m_fs = 1'b1;
          mfc = (mfc + 1) % 4;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
      m_disp = (mx < 8) && (my < 4);
      m_hs   = (mx >= 10) && (mx < 12);
      m_vs   = (my == 5);
      m_vb   = (my >= 4);
    end
  endtask

  task automatic step_small(input logic c, input string name);
    ce_s = c;
    model_step(c);
    @(posedge clk);
    @(negedge clk);
    check_output(name, small_act(), small_exp());
  endtask

  initial begin
    int hs_low, ls_cnt, fs_cnt, last_fs, max_fc;

    vecs[0] = '{1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 3, 0, 1'b1, 1'b1, 1'b0, 1'b0};

    reset_n = 1'b0;
    ce      = 1'b0;
    ce_s    = 1'b0;
    model_reset();
    @(negedge clk);
    check_output("reset_def", def_act(), pack_def(0, 0, 0, 1, 1, 0, 0, 0, 0));
    check_output("reset_small", small_act(), small_exp());

    // Released but no enable yet: nothing may move.
    reset_n = 1'b1;
    apply_stimulus(1'b0, 2);
    check_output("idle_hold", def_act(), pack_def(0, 0, 0, 1, 1, 0, 0, 0, 0));

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].ce, 1);
      check_output($sformatf("vec%0d", i), def_act(),
                   pack_def(vecs[i].x, vecs[i].y, vecs[i].disp, vecs[i].hs, 1'b1, 1'b0,
                            vecs[i].ls, vecs[i].fs, 0));
    end

    // Horizontal boundaries of the first default line.
    apply_stimulus(1'b1, 636);
    check_output("x639", def_act(), pack_def(639, 0, 1, 1, 1, 0, 0, 0, 0));
    apply_stimulus(1'b1, 1);
    check_output("x640", def_act(), pack_def(640, 0, 0, 1, 1, 0, 0, 0, 0));
    apply_stimulus(1'b1, 15);
    check_output("x655", def_act(), pack_def(655, 0, 0, 1, 1, 0, 0, 0, 0));
    apply_stimulus(1'b1, 1);
    check_output("x656", def_act(), pack_def(656, 0, 0, 0, 1, 0, 0, 0, 0));
    apply_stimulus(1'b1, 95);
    check_output("x751", def_act(), pack_def(751, 0, 0, 0, 1, 0, 0, 0, 0));
    apply_stimulus(1'b1, 1);
    check_output("x752", def_act(), pack_def(752, 0, 0, 1, 1, 0, 0, 0, 0));
    apply_stimulus(1'b1, 47);
    check_output("x799", def_act(), pack_def(799, 0, 0, 1, 1, 0, 0, 0, 0));
    apply_stimulus(1'b1, 1);
    check_output("line1", def_act(), pack_def(0, 1, 1, 1, 1, 0, 1, 0, 0));

    hs_low = 0;
    ls_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      apply_stimulus(1'b1, 1);
      if (hsync == 1'b0) hs_low++;
      if (line_start) ls_cnt++;
    end
    check_output("hs_low_count", 64'(hs_low), 64'd96);
    check_output("ls_per_line", 64'(ls_cnt), 64'd1);
    check_output("line2", def_act(), pack_def(0, 2, 1, 1, 1, 0, 1, 0, 0));
    apply_stimulus(1'b1, 300);
    check_output("x300y2", def_act(), pack_def(300, 2, 1, 1, 1, 0, 0, 0, 0));
    ce = 1'b0;

    // Small raster: four full frames plus the start edge, ce held high.
    fs_cnt  = 0;
    ls_cnt  = 0;
    last_fs = 0;
    max_fc  = 0;
    for (int i = 1; i <= 393; i++) begin
      step_small(1'b1, $sformatf("small_run%0d", i));
      if (s_line_start) ls_cnt++;
      if (int'(s_frame_count) > max_fc) max_fc = int'(s_frame_count);
      if (s_frame_start) begin
        if (fs_cnt > 0) check_output("fs_interval", 64'(i - last_fs), 64'd98);
        fs_cnt++;
        last_fs = i;
      end
    end
    check_output("fs_count", 64'(fs_cnt), 64'd5);
    check_output("ls_count", 64'(ls_cnt), 64'd29);
    check_output("fc_max", 64'(max_fc), 64'd3);
    check_output("fc_wrapped", 64'(s_frame_count), 64'd0);

    // One enable in four: strobes stay one clk wide, levels hold between enables.
    for (int i = 0; i < 200; i++) begin
      step_small(i % 4 == 0, $sformatf("small_ce%0d", i));
    end
    check_output("def_hold", def_act(), pack_def(300, 2, 1, 1, 1, 0, 0, 0, 0));

    // Reset in the middle of a clock low phase must act before the next edge.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_output("async_rst_def", def_act(), pack_def(0, 0, 0, 1, 1, 0, 0, 0, 0));
    check_output("async_rst_small", small_act(), small_exp());
    @(negedge clk);
    reset_n = 1'b1;
    ce   = 1'b1;
    ce_s = 1'b1;
    model_step(1'b1);
    @(posedge clk);
    @(negedge clk);
    check_output("restart_def0", def_act(), pack_def(0, 0, 1, 1, 1, 0, 1, 1, 0));
    check_output("restart_small0", small_act(), small_exp());
    model_step(1'b1);
    @(posedge clk);
    @(negedge clk);
    check_output("restart_def1", def_act(), pack_def(1, 0, 1, 1, 1, 0, 0, 0, 0));
    check_output("restart_small1", small_act(), small_exp());
    ce   = 1'b0;
    ce_s = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
